iob_cache_arbiter: RTL and testbench
====================================

IOB_CACHE_ARBITER -- requirements
Module: iob_cache_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2; number of IOb requesters, legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32; IOb address width.
REQ-003 SHALL have parameter DATA_W, default 32; IOb data width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state is updated on the rising edge.
REQ-005 SHALL have port arst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cke_i  input  1  clock enable; when low, all registers hold their value.
REQ-007 SHALL have port s_avalid_i  input  N_REQ  per-requester request valid.
REQ-008 SHALL have port s_addr_i  input  N_REQ*ADDR_W  requester addresses, requester i in slice i.
REQ-009 SHALL have port s_wdata_i  input  N_REQ*DATA_W  write data.
REQ-010 SHALL have port s_wstrb_i  input  N_REQ*DATA_W/8  write strobes; any bit set marks a write.
REQ-011 SHALL have port s_acache_i  input  N_REQ*4  cache attributes.
REQ-012 SHALL have port s_ready_o  output  N_REQ  per-requester accept.
REQ-013 SHALL have port s_rvalid_o  output  N_REQ  per-requester read-data valid.
REQ-014 SHALL have port s_rdata_o  output  DATA_W  read data, broadcast to all requesters.
REQ-015 SHALL have the following downstream ports to the cache front-end: m_avalid_o, m_addr_o, m_wdata_o, m_wstrb_o, m_acache_o (outputs), and m_rvalid_i, m_rdata_i, m_ready_i (inputs).
REQ-016 SHALL have port grant_o  output  $clog2(N_REQ)  index of the current or last granted requester.
REQ-017 SHALL have port busy_o  output  1  high in the HOLD and WAIT states.

Function
REQ-018 SHALL implement FSM states IDLE, HOLD and WAIT, with exactly one transaction outstanding downstream.
REQ-019 SHALL, in IDLE, select the candidate combinationally by round-robin: the first requester with s_avalid_i set, searching from (last_grant+1) mod N_REQ upward with wrap-around.
REQ-020 SHALL, in IDLE or HOLD, drive m_avalid_o high and mux the candidate's addr, wdata, wstrb and acache onto the m_* outputs.
REQ-021 SHALL define acceptance as m_avalid_o and m_ready_i high in the same cycle; on acceptance, assert s_ready_o[candidate] for that cycle only, register the grant index and the write flag (|wstrb), update last_grant, and go to WAIT.
REQ-022 SHALL, when the candidate is presented in IDLE with m_ready_i low, lock the index and go to HOLD; in HOLD the locked index SHALL NOT change, even if a higher-priority request arrives.
REQ-023 SHALL drive m_avalid_o low in WAIT, and drive s_ready_o low for all requesters in HOLD-without-acceptance and in WAIT.
REQ-024 SHALL, in WAIT, route s_rvalid_o[grant] = m_rvalid_i & ~write flag; all other s_rvalid_o bits SHALL be 0. s_rdata_o SHALL equal m_rdata_i at all times.
REQ-025 SHALL return from WAIT to IDLE on the first cycle m_ready_i is high, and SHALL NOT accept a new request in that same cycle, so there is one idle cycle between transactions.
REQ-026 SHALL hold all outputs stable in IDLE when no request is pending: m_avalid_o=0, s_ready_o=0, s_rvalid_o=0.
REQ-027 SHALL ignore (not sample) a requester that drops s_avalid_i while in HOLD; the locked request SHALL still be issued. Requesters are required not to do this.

Reset
REQ-028 SHALL, while arst_i is high, immediately force state=IDLE, last_grant=N_REQ-1 (so requester 0 wins first), grant_o=0, write flag=0, busy_o=0, m_avalid_o=0, s_ready_o=0 and s_rvalid_o=0.
REQ-029 SHALL, when reset is asserted mid-transaction, drop the outstanding transaction without any response to the requester; the downstream side is reset by the same arst_i.

Structure
REQ-030 SHALL place the FSM state encoding localparams (IDLE=2'd0, HOLD=2'd1, WAIT=2'd2) in the shared iob_cache conf header.
REQ-031 SHALL implement the round-robin search in one sub-module, iob_cache_rr_prio: a combinational priority encoder taking the request vector and last_grant and producing the index and a found flag.
REQ-032 SHALL implement all registers with iob_reg_re instances (clk_i, arst_i, cke_i).

Verification
REQ-033 Reset: assert arst_i mid-WAIT -> state=IDLE, busy_o=0, and no s_rvalid_o is ever produced for the dropped read.
REQ-034 Fairness: N_REQ=2, both requesters issue continuous reads with m_ready_i=1 -> grants alternate 0,1,0,1, with s_ready_o pulses 2 cycles apart.
REQ-035 Read routing: requester 1 reads addr 0x40 and the memory returns 0xDEADBEEF -> s_rvalid_o=2'b10 for exactly one cycle, and s_rdata_o=0xDEADBEEF in that cycle.
REQ-036 Write: requester 0 writes with wstrb=4'hF -> m_wstrb_o=4'hF at acceptance, s_rvalid_o stays 0, and the FSM returns to IDLE on m_ready_i.
REQ-037 HOLD: m_ready_i held low for 3 cycles with requester 0 pending, then requester 1 raises s_avalid_i -> m_addr_o stays on requester 0, and requester 0 is accepted when m_ready_i rises.
REQ-038 Clock enable: hold cke_i=0 for 5 cycles during WAIT -> state and grant_o are unchanged, then normal completion follows.

Source files
------------

// File: rtl/iob_cache_arbiter_pkg.sv
// iob_cache_arbiter_pkg -- shared iob_cache configuration for the arbiter.
//   Holds the FSM state encoding used by iob_cache_arbiter.
package iob_cache_arbiter_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE = 2'd0;
  localparam logic [STATE_W-1:0] HOLD = 2'd1;
  localparam logic [STATE_W-1:0] WAIT = 2'd2;

endpackage

// File: rtl/iob_cache_rr_prio.sv
// iob_cache_rr_prio -- combinational round-robin priority encoder.
//   req_i   : request vector
//   last_i  : index granted last time
//   idx_o   : first set request searching from last_i+1 with wrap-around
//   found_o : any request set
module iob_cache_rr_prio #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Walk from the lowest-priority offset down to the highest so that the
  // last hit written is the winner; no early exit needed.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      int j;
      j = (int'(last_i) + k) % N_REQ;
      if (req_i[j]) begin
        idx_o   = IDX_W'(j);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_reg_re.sv
// iob_reg_re -- register with async reset, clock enable, sync reset and enable.
//   clk_i, arst_i (async, active-high), cke_i (clock enable),
//   rst_i (sync reset to RST_VAL), en_i (load enable), data_i -> data_o.
module iob_reg_re #(
  parameter int              DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)      data_o <= RST_VAL;
    else if (cke_i) begin
      if (rst_i)     data_o <= RST_VAL;
      else if (en_i) data_o <= data_i;
    end
  end

endmodule

// File: rtl/iob_cache_arbiter.sv
// iob_cache_arbiter -- round-robin arbiter of N_REQ IOb requesters onto one
// cache front-end port, one transaction outstanding at a time.
//   clk_i, arst_i (async, active-high), cke_i (clock enable)
//   s_*   : requester side (avalid/addr/wdata/wstrb/acache in, ready/rvalid/rdata out)
//   m_*   : cache side (avalid/addr/wdata/wstrb/acache out, ready/rvalid/rdata in)
//   grant_o : current or last granted requester, busy_o : in HOLD or WAIT
module iob_cache_arbiter
  import iob_cache_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int IDX_W  = $clog2(N_REQ),
  localparam int STRB_W = DATA_W/8
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      cke_i,
  input  logic [N_REQ-1:0]          s_avalid_i,
  input  logic [N_REQ*ADDR_W-1:0]   s_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   s_wdata_i,
  input  logic [N_REQ*STRB_W-1:0]   s_wstrb_i,
  input  logic [N_REQ*4-1:0]        s_acache_i,
  output logic [N_REQ-1:0]          s_ready_o,
  output logic [N_REQ-1:0]          s_rvalid_o,
  output logic [DATA_W-1:0]         s_rdata_o,
  output logic                      m_avalid_o,
  output logic [ADDR_W-1:0]         m_addr_o,
  output logic [DATA_W-1:0]         m_wdata_o,
  output logic [STRB_W-1:0]         m_wstrb_o,
  output logic [3:0]                m_acache_o,
  input  logic                      m_rvalid_i,
  input  logic [DATA_W-1:0]         m_rdata_i,
  input  logic                      m_ready_i,
  output logic [IDX_W-1:0]          grant_o,
  output logic                      busy_o
);

  logic [STATE_W-1:0] state, state_nxt;
  logic [IDX_W-1:0]   last_grant, last_grant_nxt;
  logic [IDX_W-1:0]   grant, grant_nxt;
  logic               wr, wr_nxt;
  logic [IDX_W-1:0]   cand, sel;
  logic               found, m_av, accept, req_wr;
  logic [N_REQ-1:0]   rvalid;

  iob_cache_rr_prio #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_prio (
    .req_i(s_avalid_i), .last_i(last_grant), .idx_o(cand), .found_o(found)
  );

  // In HOLD the locked index drives the mux; late higher-priority requests
  // and a dropped avalid are ignored.
  assign sel    = (state == HOLD) ? grant : cand;
  assign req_wr = |s_wstrb_i[sel*STRB_W +: STRB_W];

  assign m_addr_o   = s_addr_i[sel*ADDR_W +: ADDR_W];
  assign m_wdata_o  = s_wdata_i[sel*DATA_W +: DATA_W];
  assign m_wstrb_o  = s_wstrb_i[sel*STRB_W +: STRB_W];
  assign m_acache_o = s_acache_i[sel*4 +: 4];
  assign s_rdata_o  = m_rdata_i;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    wr_nxt         = wr;
    m_av           = 1'b0;
    accept         = 1'b0;
    rvalid         = '0;
    case (state)
      IDLE: if (found) begin
        m_av      = 1'b1;
        grant_nxt = cand;
        if (m_ready_i) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end else begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        m_av = 1'b1;
        if (m_ready_i) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        rvalid[grant] = m_rvalid_i & ~wr;
        // No acceptance here: the return to IDLE costs one idle cycle.
        if (m_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      grant_nxt      = sel;
      last_grant_nxt = sel;
      wr_nxt         = req_wr;
    end
  end

  // A ready pulse only when the FSM actually advances, so a frozen clock
  // enable cannot hand out the same acceptance twice.
  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      s_ready_o[i] = accept & cke_i & ~arst_i & (sel == IDX_W'(i));
  end

  assign m_avalid_o = m_av & ~arst_i;
  assign s_rvalid_o = arst_i ? '0 : rvalid;
  assign grant_o    = grant;
  assign busy_o     = (state != IDLE);

  iob_reg_re #(.DATA_W(STATE_W), .RST_VAL(IDLE)) u_state_reg (
    .clk_i, .arst_i, .cke_i, .rst_i(1'b0), .en_i(1'b1),
    .data_i(state_nxt), .data_o(state)
  );

  iob_reg_re #(.DATA_W(IDX_W), .RST_VAL(IDX_W'(N_REQ-1))) u_last_reg (
    .clk_i, .arst_i, .cke_i, .rst_i(1'b0), .en_i(1'b1),
    .data_i(last_grant_nxt), .data_o(last_grant)
  );

  iob_reg_re #(.DATA_W(IDX_W), .RST_VAL('0)) u_grant_reg (
    .clk_i, .arst_i, .cke_i, .rst_i(1'b0), .en_i(1'b1),
    .data_i(grant_nxt), .data_o(grant)
  );

  iob_reg_re #(.DATA_W(1), .RST_VAL(1'b0)) u_wr_reg (
    .clk_i, .arst_i, .cke_i, .rst_i(1'b0), .en_i(1'b1),
    .data_i(wr_nxt), .data_o(wr)
  );

endmodule

// File: tb/tb_iob_cache_arbiter.sv
// tb_iob_cache_arbiter -- directed self-checking bench for iob_cache_arbiter
// (N_REQ=2, 32-bit address/data).
module tb_iob_cache_arbiter;

  localparam int N = 2;

  logic        clk_i = 1'b0;
  logic        arst_i, cke_i;
  logic [1:0]  s_avalid_i;
  logic [63:0] s_addr_i, s_wdata_i;
  logic [7:0]  s_wstrb_i, s_acache_i;
  logic [1:0]  s_ready_o, s_rvalid_o;
  logic [31:0] s_rdata_o;
  logic        m_avalid_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic [3:0]  m_wstrb_o, m_acache_o;
  logic        m_rvalid_i, m_ready_i;
  logic [31:0] m_rdata_i;
  logic [0:0]  grant_o;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  iob_cache_arbiter #(.N_REQ(N), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i),
    .s_avalid_i(s_avalid_i), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i),
    .s_wstrb_i(s_wstrb_i), .s_acache_i(s_acache_i),
    .s_ready_o(s_ready_o), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
    .m_avalid_o(m_avalid_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o), .m_acache_o(m_acache_o),
    .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i), .m_ready_i(m_ready_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    arst_i = 1'b1; cke_i = 1'b1;
    s_avalid_i = 2'b01; s_addr_i = '0; s_wdata_i = '0; s_wstrb_i = '0; s_acache_i = '0;
    m_rvalid_i = 1'b0; m_ready_i = 1'b1; m_rdata_i = '0;
    #12;
    // reset state, with a request pending
    chk("rst_avalid", m_avalid_o, 0);
    chk("rst_ready",  s_ready_o, 0);
    chk("rst_rvalid", s_rvalid_o, 0);
    chk("rst_busy",   busy_o, 0);
    chk("rst_grant",  grant_o, 0);
    s_avalid_i = 2'b00;
    tick();
    arst_i = 1'b0;
    tick();
    chk("idle_avalid", m_avalid_o, 0);

    // read routing: requester 1 reads 0x40
    s_avalid_i = 2'b10; s_addr_i[32 +: 32] = 32'h40; s_acache_i = 8'h50;
    #1;
    chk("rd_avalid", m_avalid_o, 1);
    chk("rd_addr",   m_addr_o, 32'h40);
    chk("rd_acache", m_acache_o, 4'h5);
    chk("rd_ready",  s_ready_o, 2'b10);
    tick();
    s_avalid_i = 2'b00; m_ready_i = 1'b0;
    #1;
    chk("rd_wait_busy",  busy_o, 1);
    chk("rd_wait_grant", grant_o, 1);
    chk("rd_wait_av",    m_avalid_o, 0);
    chk("rd_wait_rv0",   s_rvalid_o, 0);
    tick();
    m_ready_i = 1'b1; m_rvalid_i = 1'b1; m_rdata_i = 32'hDEADBEEF;
    #1;
    chk("rd_rvalid", s_rvalid_o, 2'b10);
    chk("rd_rdata",  s_rdata_o, 32'hDEADBEEF);
    tick();
    m_rvalid_i = 1'b0;
    #1;
    chk("rd_rvalid_once", s_rvalid_o, 0);
    chk("rd_done_busy",   busy_o, 0);

    // write: requester 0, wstrb F
    s_avalid_i = 2'b01; s_addr_i[0 +: 32] = 32'h100; s_wdata_i[0 +: 32] = 32'hCAFEF00D;
    s_wstrb_i[0 +: 4] = 4'hF;
    #1;
    chk("wr_ready", s_ready_o, 2'b01);
    chk("wr_wstrb", m_wstrb_o, 4'hF);
    chk("wr_wdata", m_wdata_o, 32'hCAFEF00D);
    tick();
    s_avalid_i = 2'b00; s_wstrb_i = '0; m_rvalid_i = 1'b1;
    #1;
    chk("wr_rvalid", s_rvalid_o, 0);
    chk("wr_busy",   busy_o, 1);
    tick();
    m_rvalid_i = 1'b0;
    chk("wr_idle", busy_o, 0);

    // HOLD: requester 0 pending with m_ready low, then requester 1 arrives
    s_avalid_i = 2'b01; s_addr_i[0 +: 32] = 32'h200; s_addr_i[32 +: 32] = 32'h300;
    m_ready_i = 1'b0;
    #1;
    chk("hold_av",    m_avalid_o, 1);
    chk("hold_ready", s_ready_o, 0);
    tick();
    chk("hold_busy", busy_o, 1);
    tick(); tick();
    s_avalid_i = 2'b11;
    #1;
    chk("hold_addr",  m_addr_o, 32'h200);
    chk("hold_grant", grant_o, 0);
    chk("hold_av2",   m_avalid_o, 1);
    m_ready_i = 1'b1;
    #1;
    chk("hold_acc",      s_ready_o, 2'b01);
    chk("hold_acc_addr", m_addr_o, 32'h200);
    tick();
    s_avalid_i = 2'b10;
    #1;
    chk("wait_noacc", s_ready_o, 0);
    tick();
    chk("next_acc", s_ready_o, 2'b10);
    tick();
    s_avalid_i = 2'b00;
    tick();

    // fairness: both requesters reading continuously, m_ready high
    s_avalid_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("fair_rdy%0d", k), s_ready_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk($sformatf("fair_gap%0d", k), s_ready_o, 0);
      chk($sformatf("fair_gnt%0d", k), grant_o, k % 2);
      tick();
    end
    s_avalid_i = 2'b00;

    // clock enable frozen during WAIT
    s_avalid_i = 2'b01;
    #1;
    chk("cke_acc", s_ready_o, 2'b01);
    tick();
    cke_i = 1'b0; s_avalid_i = 2'b10;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("cke_busy%0d", k), busy_o, 1);
      chk($sformatf("cke_gnt%0d", k), grant_o, 0);
    end
    chk("cke_ready", s_ready_o, 0);
    cke_i = 1'b1; s_avalid_i = 2'b00; m_rvalid_i = 1'b1; m_rdata_i = 32'h1234;
    #1;
    chk("cke_rvalid", s_rvalid_o, 2'b01);
    tick();
    m_rvalid_i = 1'b0;
    chk("cke_done", busy_o, 0);

    // reset in the middle of WAIT drops the read
    s_avalid_i = 2'b10;
    #1;
    chk("rwait_acc", s_ready_o, 2'b10);
    tick();
    s_avalid_i = 2'b00; m_ready_i = 1'b0;
    chk("rwait_busy", busy_o, 1);
    arst_i = 1'b1; m_rvalid_i = 1'b1; m_ready_i = 1'b1;
    #1;
    chk("rwait_rst_busy",  busy_o, 0);
    chk("rwait_rst_grant", grant_o, 0);
    chk("rwait_rst_rv",    s_rvalid_o, 0);
    tick();
    arst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rwait_rv%0d", k), s_rvalid_o, 0);
    end
    m_rvalid_i = 1'b0;
    s_avalid_i = 2'b11;
    #1;
    chk("post_rst_first", s_ready_o, 2'b01);
    tick();
    s_avalid_i = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
